// File: rtl/bsg_counter_set_en_multi.sv
// ---------------------------------------------------------------------------
// bsg_counter_set_en_multi
//
// Bank of els_p independent modulo-(max_val_p+1) counters. Each channel can
// load a value (clamped to max_val_p), step up or down, or hold. At the
// boundaries a channel either wraps or saturates, depending on saturate_p.
// Each channel also registers a one-cycle terminal-count pulse and a sticky
// overflow flag.
//
// Ports:
//   clk_i      - clock, all state changes on the rising edge
//   reset_n_i  - asynchronous active-low reset
//   set_i      - per-channel load strobe (highest priority)
//   en_i       - per-channel count enable
//   down_i     - per-channel direction (0 = up, 1 = down)
//   val_i      - load values, channel k at [k*width_p +: width_p]
//   clr_ovf_i  - per-channel clear of the sticky overflow flag
//   count_o    - registered counts, same packing as val_i
//   tc_o       - registered terminal-count pulse (one per boundary step)
//   ovf_o      - registered sticky overflow flag
// ---------------------------------------------------------------------------
module bsg_counter_set_en_multi #(
    parameter int width_p     = 8,
    parameter int els_p       = 4,
    parameter int max_val_p   = 2**width_p - 1,
    parameter int saturate_p  = 0,
    parameter int reset_val_p = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [els_p-1:0]           set_i,
    input  logic [els_p-1:0]           en_i,
    input  logic [els_p-1:0]           down_i,
    input  logic [els_p*width_p-1:0]   val_i,
    input  logic [els_p-1:0]           clr_ovf_i,
    output logic [els_p*width_p-1:0]   count_o,
    output logic [els_p-1:0]           tc_o,
    output logic [els_p-1:0]           ovf_o
);

    // One extra bit on all intermediates so max_val_p = 2**width_p-1 and
    // the +1 step never truncate silently.
    localparam logic [width_p:0]   max_lp   = (width_p+1)'(max_val_p);
    localparam logic [width_p:0]   one_lp   = (width_p+1)'(1);
    localparam logic [width_p:0]   zero_lp  = '0;
    localparam logic [width_p-1:0] reset_lp = width_p'(reset_val_p);
    localparam bit                 sat_lp   = (saturate_p != 0);

    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi = gi + 1) begin : g_ch
            logic [width_p-1:0] count_q;
            logic [width_p-1:0] count_d;
            logic               tc_q;
            logic               tc_d;
            logic               ovf_q;
            logic               ovf_d;
            logic [width_p:0]   cur_ext;
            logic [width_p:0]   val_ext;
            logic [width_p:0]   next_ext;
            logic               boundary;

            assign cur_ext = {1'b0, count_q};
            assign val_ext = {1'b0, val_i[gi*width_p +: width_p]};

            always_comb begin
                next_ext = cur_ext;
                boundary = 1'b0;
                tc_d     = 1'b0;
                // A boundary step below overrides the clear, so the set wins.
                ovf_d    = ovf_q & ~clr_ovf_i[gi];

                if (set_i[gi]) begin
                    next_ext = (val_ext > max_lp) ? max_lp : val_ext;
                end else if (en_i[gi]) begin
                    if (down_i[gi]) begin
                        if (cur_ext == zero_lp) begin
                            boundary = 1'b1;
                            next_ext = sat_lp ? zero_lp : max_lp;
                        end else begin
                            next_ext = cur_ext - one_lp;
                        end
                    end else begin
                        // With max_val_p = 0 this branch is always taken,
                        // so the count stays 0 and every step pulses tc.
                        if (cur_ext == max_lp) begin
                            boundary = 1'b1;
                            next_ext = sat_lp ? max_lp : zero_lp;
                        end else begin
                            next_ext = cur_ext + one_lp;
                        end
                    end
                end

                if (boundary) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end

                count_d = next_ext[width_p-1:0];
            end

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    count_q <= reset_lp;
                    tc_q    <= 1'b0;
                    ovf_q   <= 1'b0;
                end else begin
                    count_q <= count_d;
                    tc_q    <= tc_d;
                    ovf_q   <= ovf_d;
                end
            end

            assign count_o[gi*width_p +: width_p] = count_q;
            assign tc_o[gi]                       = tc_q;
            assign ovf_o[gi]                      = ovf_q;
        end
    endgenerate

endmodule
